rll27_decoder: RTL and testbench

Receive-side counterpart of the RLL(2,7) encoder. Accepts the NRZI channel stream one level per strobe. Converts it back to transition bits and parses the variable-length (2,7) codewords. Emits each decoded data group as a left-aligned 4-bit word with a length field. Tracks codeword errors and lock status for the link-level monitor.

---
 rtl/rll27_pkg.sv | 57 +++++
 rtl/rll27_decoder_if.sv | 25 ++
 rtl/rll27_decoder_nrzi_to_trans.sv | 21 ++
 rtl/rll27_decoder.sv | 110 +++++++++++
 tb/tb_rll27_decoder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/rll27_pkg.sv
// Shared types, codeword tables and the pair-boundary classifier for the RLL(2,7) decoder.
package rll27_pkg;

  typedef logic [2:0] len_t;

  typedef enum logic [1:0] {
    K_MORE = 2'd0,
    K_DONE = 2'd1,
    K_ERR  = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] dat;
    len_t       len;
  } step_t;

  localparam int unsigned NUM_CW  = 7;
  localparam int unsigned NUM_PFX = 9;

  // Channel patterns are right-aligned: the first received bit is the MSB of the CW_NCH-bit field.
  localparam logic [7:0] CW_PAT [NUM_CW] = '{8'b0000_1000, 8'b0000_0100, 8'b0000_0100, 8'b0010_0100,
                                             8'b0000_1000, 8'b0000_1000, 8'b0010_0100};
  localparam logic [3:0] CW_NCH [NUM_CW] = '{4'd4, 4'd4, 4'd6, 4'd6, 4'd6, 4'd8, 4'd8};
  localparam logic [3:0] CW_DAT [NUM_CW] = '{4'b1100, 4'b1000, 4'b0000, 4'b0100,
                                             4'b0110, 4'b0011, 4'b0010};
  localparam len_t       CW_LEN [NUM_CW] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};

  localparam logic [7:0] PFX_PAT [NUM_PFX] = '{8'b10, 8'b01, 8'b00,
                                               8'b1001, 8'b0010, 8'b0001, 8'b0000,
                                               8'b001001, 8'b000010};
  localparam logic [3:0] PFX_NCH [NUM_PFX] = '{4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd6, 4'd6};

  // Anything that is neither a complete codeword nor a legal prefix (including any n=8 miss) is an error.
  function automatic step_t classify(input logic [7:0] b, input logic [3:0] n);
    step_t      r;
    logic [7:0] msk;
    logic [7:0] bm;
    r.kind = K_ERR;
    r.dat  = '0;
    r.len  = '0;
    msk    = ~(8'hFF << n);
    bm     = b & msk;
    for (int i = 0; i < int'(NUM_PFX); i++) begin
      if (n == PFX_NCH[i] && bm == PFX_PAT[i]) r.kind = K_MORE;
    end
    for (int i = 0; i < int'(NUM_CW); i++) begin
      if (n == CW_NCH[i] && bm == CW_PAT[i]) begin
        r.kind = K_DONE;
        r.dat  = CW_DAT[i];
        r.len  = CW_LEN[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rll27_decoder_if.sv
// Channel-in / decoded-group-out bundle of the RLL(2,7) decoder.
interface rll27_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  import rll27_pkg::*;

  logic             ch_i;
  logic             ch_vld_i;
  logic [3:0]       dat_o;
  len_t             len_o;
  logic             vld_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic             locked_o;

  modport master (
    output ch_i, ch_vld_i,
    input  dat_o, len_o, vld_o, err_o, err_cnt_o, locked_o
  );

  modport slave (
    input  ch_i, ch_vld_i,
    output dat_o, len_o, vld_o, err_o, err_cnt_o, locked_o
  );
endinterface

// File: rtl/rll27_decoder_nrzi_to_trans.sv
// NRZI level-to-transition converter; holds the last accepted channel level.
module nrzi_to_trans (
  input  logic clk_i,
  input  logic arst_i,
  input  logic ch_i,
  input  logic ch_vld_i,
  output logic t_c,
  output logic t_vld_c
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i)       prev_q <= 1'b0;
    else if (ch_vld_i) prev_q <= ch_i;
  end

  assign t_c     = ch_i ^ prev_q;
  assign t_vld_c = ch_vld_i;

endmodule

// File: rtl/rll27_decoder.sv
// RLL(2,7) receive decoder: NRZI undo, variable-length codeword parse, lock and error tracking.
module rll27_decoder
  import rll27_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input logic            clk_i,
  input logic            arst_i,
  rll27_decoder_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  logic              t_c;
  logic              t_vld_c;
  logic [7:0]        buf_q,  buf_d;
  logic [3:0]        n_q,    n_d;
  logic [3:0]        dat_q,  dat_d;
  len_t              len_q,  len_d;
  logic              vld_q,  vld_d;
  logic              err_q,  err_d;
  logic [ERR_W-1:0]  errc_q, errc_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q;
  logic [7:0]        nb_c;
  logic [3:0]        nn_c;
  step_t             step_c;

  nrzi_to_trans u_nrzi (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .ch_i     (bus.ch_i),
    .ch_vld_i (bus.ch_vld_i),
    .t_c      (t_c),
    .t_vld_c  (t_vld_c)
  );

  assign nb_c   = {buf_q[6:0], t_c};
  assign nn_c   = n_q + 4'd1;
  assign step_c = classify(nb_c, nn_c);

  // Accumulate, and at each pair boundary emit, keep going, or discard and re-align.
  always_comb begin
    buf_d  = buf_q;
    n_d    = n_q;
    dat_d  = dat_q;
    len_d  = '0;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    errc_d = errc_q;
    good_d = good_q;
    if (t_vld_c) begin
      buf_d = nb_c;
      n_d   = nn_c;
      if (!nn_c[0]) begin
        unique case (step_c.kind)
          K_DONE: begin
            vld_d = 1'b1;
            dat_d = step_c.dat;
            len_d = step_c.len;
            buf_d = '0;
            n_d   = '0;
            if (good_q != GOOD_W'(LOCK_CNT)) good_d = good_q + GOOD_W'(1);
          end
          K_MORE: ;
          default: begin
            err_d  = 1'b1;
            buf_d  = '0;
            n_d    = '0;
            good_d = '0;
            if (errc_q != '1) errc_d = errc_q + ERR_W'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      buf_q    <= '0;
      n_q      <= '0;
      dat_q    <= '0;
      len_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      errc_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      n_q      <= n_d;
      dat_q    <= dat_d;
      len_q    <= len_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      errc_q   <= errc_d;
      good_q   <= good_d;
      locked_q <= (good_d == GOOD_W'(LOCK_CNT));
    end
  end

  assign bus.dat_o     = dat_q;
  assign bus.len_o     = len_q;
  assign bus.vld_o     = vld_q;
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = errc_q;
  assign bus.locked_o  = locked_q;

endmodule

// File: tb/tb_rll27_decoder.sv
// Scoreboard bench for rll27_decoder: transition strings in, expected groups/errors queued and matched on output pulses.
module tb_rll27_decoder;
  import rll27_pkg::*;

  localparam int unsigned ERR_W    = 2;
  localparam int unsigned LOCK_CNT = 4;

  typedef struct {
    bit         is_err;
    logic [3:0] dat;
    logic [2:0] len;
    int         errs;
    bit         locked;
    int         cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic arst_i;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  // Reference state kept by the bench from the link-level rules.
  int         m_good = 0;
  int         m_errs = 0;
  logic       m_lvl = 1'b0;
  logic [3:0] last_dat = 4'd0;

  rll27_decoder_if #(.ERR_W(ERR_W)) bus ();

  rll27_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive_bit(input logic t, input bit gap);
    m_lvl        = m_lvl ^ t;
    bus.ch_i     = m_lvl;
    bus.ch_vld_i = 1'b1;
    @(negedge clk_i);
    bus.ch_vld_i = 1'b0;
    if (gap) @(negedge clk_i);
  endtask

  // Send one codeword/bad-pair run of transitions; the expectation is queued before its last bit.
  task automatic send(input string s, input bit is_err, input logic [3:0] d,
                      input logic [2:0] l, input bit gap);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) begin
        if (is_err) begin
          m_good = 0;
          if (m_errs < (1 << ERR_W) - 1) m_errs++;
        end else if (m_good < int'(LOCK_CNT)) begin
          m_good++;
        end
        e.is_err = is_err;
        e.dat    = d;
        e.len    = l;
        e.errs   = m_errs;
        e.locked = (m_good == int'(LOCK_CNT));
        e.cyc    = cyc + 1;
        sb.push_back(e);
      end
      drive_bit(s[i] == "1", gap);
    end
  endtask

  always @(negedge clk_i) begin
    if (arst_i === 1'b1 && (bus.vld_o || bus.err_o)) begin
      exp_t e;
      check("excl", 32'(bus.vld_o & bus.err_o), 32'd0);
      if (sb.size() == 0) begin
        check("spurious", 32'(bus.vld_o | bus.err_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("kind",   32'(bus.err_o), 32'(e.is_err));
        check("cycle",  32'(cyc), 32'(e.cyc));
        check("errcnt", 32'(bus.err_cnt_o), 32'(e.errs));
        check("locked", 32'(bus.locked_o), 32'(e.locked));
        if (e.is_err) begin
          check("len_err",  32'(bus.len_o), 32'd0);
          check("dat_hold", 32'(bus.dat_o), 32'(last_dat));
        end else begin
          check("dat", 32'(bus.dat_o), 32'(e.dat));
          check("len", 32'(bus.len_o), 32'(e.len));
          last_dat = e.dat;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dat"},    32'(bus.dat_o), 32'd0);
    check({tag, "_len"},    32'(bus.len_o), 32'd0);
    check({tag, "_vld"},    32'(bus.vld_o), 32'd0);
    check({tag, "_err"},    32'(bus.err_o), 32'd0);
    check({tag, "_errcnt"}, 32'(bus.err_cnt_o), 32'd0);
    check({tag, "_locked"}, 32'(bus.locked_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_i       = 1'b0;
    bus.ch_i     = 1'b0;
    bus.ch_vld_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    arst_i = 1'b1;
    @(negedge clk_i);

    send("1000",     1'b0, 4'b1100, 3'd2, 1'b0);
    send("00100100", 1'b0, 4'b0010, 3'd4, 1'b0);
    send("0100",     1'b0, 4'b1000, 3'd2, 1'b1);
    send("000100",   1'b0, 4'b0000, 3'd3, 1'b1);
    send("001000",   1'b0, 4'b0110, 3'd3, 1'b1);
    repeat (2) @(negedge clk_i);
    check("locked_idle", 32'(bus.locked_o), 32'd1);
    check("len_idle",    32'(bus.len_o), 32'd0);

    send("11",       1'b1, 4'd0,    3'd0, 1'b0);
    send("1000",     1'b0, 4'b1100, 3'd2, 1'b0);
    send("100100",   1'b0, 4'b0100, 3'd3, 1'b0);
    send("00001000", 1'b0, 4'b0011, 3'd4, 1'b1);

    send("1010",     1'b1, 4'd0, 3'd0, 1'b0);
    send("000000",   1'b1, 4'd0, 3'd0, 1'b0);
    send("11",       1'b1, 4'd0, 3'd0, 1'b1);
    send("11",       1'b1, 4'd0, 3'd0, 1'b0);
    send("11",       1'b1, 4'd0, 3'd0, 1'b0);
    repeat (2) @(negedge clk_i);
    check("errcnt_sat", 32'(bus.err_cnt_o), 32'd3);

    // Partial codeword, then reset: the partial must be discarded.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    arst_i = 1'b0;
    m_good = 0;
    m_errs = 0;
    m_lvl  = 1'b0;
    last_dat = 4'd0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    arst_i = 1'b1;
    @(negedge clk_i);
    send("0100", 1'b0, 4'b1000, 3'd2, 1'b0);
    send("1000", 1'b0, 4'b1100, 3'd2, 1'b1);

    repeat (5) @(negedge clk_i);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
